imem_fetch_responder: RTL
=========================

Name: imem_fetch_responder

Overview:
- Synthesizable instruction-memory responder that serves the core's imem fetch requests (io_imem_req_* side) inside the Sodor tile.
- Word-addressed scratchpad mapped at the text base, with a ready/valid request/response handshake and one-cycle read latency.
- Flags misaligned and out-of-range fetches with an error bit.
- A backdoor load port lets benches and boot logic write program words without $readmemh.

Parameters:
- BASE_ADDR, 32'h80000000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 2.
- IDX_W, log2(DEPTH_WORDS), word-index width (derived).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- io_req_valid  in  1  fetch request valid.
- io_req_ready  out  1  responder can accept a request this cycle.
- io_req_bits_addr  in  32  fetch byte address.
- io_resp_valid  out  1  response valid.
- io_resp_ready  in  1  core accepts the response.
- io_resp_bits_data  out  32  instruction word.
- io_resp_bits_err  out  1  1 = misaligned or out-of-range fetch.
- io_load_en  in  1  backdoor write strobe.
- io_load_addr  in  32  backdoor byte address.
- io_load_data  in  32  backdoor write data.
- io_req_count  out  32  accepted-request counter; wraps.
- io_err_count  out  16  error-response counter; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release):
  - io_resp_valid=0, io_resp_bits_data=0, io_resp_bits_err=0.
  - Both counters = 0.
  - Array contents are not cleared.
- Accept rule: fire = io_req_valid && io_req_ready.
  - io_req_ready = !io_resp_valid || io_resp_ready (combinational; no other stall source).
- Latency: a request accepted at edge N produces io_resp_valid=1 after edge N, visible in cycle N+1.
  - Back-to-back: one accept per cycle while io_resp_ready=1.
- Hold: while io_resp_valid && !io_resp_ready, io_resp_bits_data and io_resp_bits_err stay stable and no new request is accepted.
- io_resp_valid clears on the edge where io_resp_ready=1 and no new fire occurs. If a fire occurs on that same edge, io_resp_valid stays 1 with the new data.
- Address decode: off = addr - BASE_ADDR (32-bit unsigned wrap); idx = off[IDX_W+1:2].
  - in_range = (off < 4*DEPTH_WORDS).
  - aligned = (addr[1:0] == 0).
- Response contents:
  - aligned && in_range: data = mem[idx], err = 0.
  - Otherwise: data = 32'h0, err = 1.
- Load port: when io_load_en is high, mem[idx(io_load_addr)] <= io_load_data on the edge, only if that address is aligned and in range; otherwise ignored silently.
  - Load is allowed in any cycle, independent of the handshake.
- Same-edge load and fire to the same word: the response returns the OLD word (read-before-write). The next fetch sees the new word.
- Counters:
  - io_req_count increments on every fire.
  - io_err_count increments on every fire whose response will carry err=1.
- Reset mid-operation: a pending response is dropped (io_resp_valid -> 0 immediately on assert). A load in flight at reset assertion may or may not land.
- Address wrap: an address below BASE_ADDR wraps to a huge off, so it is out of range and yields err=1.

Test Plan:
- Load mem[0..3] = 32'h00000297, 32'h00000013, 32'hDEADBEEF, 32'h12345678 via load port.
  - Fetch 0x80000000, 0x80000008 with io_resp_ready=1 -> responses 0x00000297 and 0xDEADBEEF in consecutive cycles, err=0, io_req_count=2.
- Fetch 0x80000004 with io_resp_ready held low 5 cycles:
  - io_resp_valid=1 with data 0x00000013 stable throughout.
  - io_req_ready=0 throughout; a second request 0x8000000C is not accepted until io_resp_ready rises, then returns 0x12345678 next cycle.
- Fetch 0x80000002 (misaligned), 0x80001000 (== BASE+4*1024), and 0x7FFFFFFC -> each returns data=0, err=1; io_err_count=3.
- Same edge: load 0x80000008 <= 32'hCAFEF00D and fetch 0x80000008.
  - Response = 0xDEADBEEF.
  - Following fetch of 0x80000008 = 0xCAFEF00D.
- Assert reset while io_resp_valid=1 and io_resp_ready=0 -> io_resp_valid, data, err, and both counters read 0 in the same cycle. After release, a fetch of 0x80000000 still returns 0x00000297 (array preserved).
- Load at 0x80001000 (out of range), then fetch 0x80000000 -> unchanged 0x00000297.
  - Streaming 300 fetches with a random io_resp_ready pattern -> io_req_count equals the number of observed response handshakes.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the core's imem fetch port: word scratchpad at BASE_ADDR,
// one-cycle read latency, ready/valid handshake, error flag and backdoor load port.
module imem_fetch_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [31:0] io_req_bits_addr,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [31:0] io_resp_bits_data,
  output logic        io_resp_bits_err,
  input  logic        io_load_en,
  input  logic [31:0] io_load_addr,
  input  logic [31:0] io_load_data,
  output logic [31:0] io_req_count,
  output logic [15:0] io_err_count
);

  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic             r_resp_valid;
  logic [31:0]      r_resp_data;
  logic             r_resp_err;
  logic [31:0]      r_req_count;
  logic [15:0]      r_err_count;

  logic [31:0]      w_req_off;
  logic             w_req_ok;
  logic [IDX_W-1:0] w_req_idx;
  logic [31:0]      w_load_off;
  logic             w_load_ok;
  logic [IDX_W-1:0] w_load_idx;
  logic             w_req_ready;
  logic             w_fire;

  // Address decode; offsets wrap, so addresses below the base land out of range.
  assign w_req_off  = io_req_bits_addr - BASE_ADDR;
  assign w_req_ok   = (w_req_off < SPAN_BYTES) && (io_req_bits_addr[1:0] == 2'b00);
  assign w_req_idx  = w_req_off[IDX_W+1:2];
  assign w_load_off = io_load_addr - BASE_ADDR;
  assign w_load_ok  = (w_load_off < SPAN_BYTES) && (io_load_addr[1:0] == 2'b00);
  assign w_load_idx = w_load_off[IDX_W+1:2];

  assign w_req_ready = !r_resp_valid || io_resp_ready;
  assign w_fire      = io_req_valid && w_req_ready;

  // Backdoor write; the fetch path reads the pre-edge word on a same-edge collision.
  always_ff @(posedge clock) begin
    if (io_load_en && w_load_ok) begin
      r_mem[w_load_idx] <= io_load_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'h0;
      r_resp_err   <= 1'b0;
    end else if (w_fire) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= w_req_ok ? r_mem[w_req_idx] : 32'h0;
      r_resp_err   <= !w_req_ok;
    end else if (io_resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  // Request counter wraps; error counter saturates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req_count <= 32'h0;
      r_err_count <= 16'h0;
    end else if (w_fire) begin
      r_req_count <= r_req_count + 32'd1;
      if (!w_req_ok && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign io_req_ready      = w_req_ready;
  assign io_resp_valid     = r_resp_valid;
  assign io_resp_bits_data = r_resp_data;
  assign io_resp_bits_err  = r_resp_err;
  assign io_req_count      = r_req_count;
  assign io_err_count      = r_err_count;

endmodule
